// File: rtl/credit_sender.sv
// Transmit end of a credit-flow link: accepts producer items over a valid/ready
// handshake, forwards them for one cycle each, and tracks far-end free slots.
module credit_sender #(
  parameter type         data_t = logic [31:0],
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  data_t         enq_data,
  output logic          tx_valid,
  output data_t         tx_data,
  input  logic          credit_in,
  input  logic          flush,
  output logic [CW-1:0] credits,
  output logic          idle,
  output logic          overflow
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          send;
  logic [CW-1:0] credits_nxt;
  logic          tx_valid_nxt;
  logic          ovf_set;

  // Ready is a function of registered credits and flush only, never enq_valid.
  assign enq_ready = (credits != '0) && !flush;
  assign send      = enq_valid && enq_ready;

  // Credit bookkeeping; flush wins over both send and a returned credit.
  always_comb begin
    credits_nxt  = credits;
    ovf_set      = 1'b0;
    tx_valid_nxt = send;
    if (flush) begin
      credits_nxt  = FULL;
      tx_valid_nxt = 1'b0;
    end else if (send && !credit_in) begin
      credits_nxt = credits - CW'(1);
    end else if (credit_in && !send) begin
      if (credits == FULL) begin
        ovf_set = 1'b1;
      end else begin
        credits_nxt = credits + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits  <= FULL;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      idle     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      credits  <= credits_nxt;
      tx_valid <= tx_valid_nxt;
      idle     <= (credits_nxt == FULL) && !tx_valid_nxt;
      if (send) begin
        tx_data <= enq_data;
      end
      // Sticky until reset; flush deliberately leaves it set.
      if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

  a_credit_range: assert property (@(posedge clk) disable iff (rst) credits <= FULL);

endmodule

// File: tb/tb_credit_sender.sv
// Directed bench for credit_sender: vector table plus async-reset and DEPTH=1 sequences.
module tb_credit_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic       enq_valid, enq_ready, credit_in, flush;
  logic [7:0] enq_data, tx_data;
  logic       tx_valid, idle, overflow;
  logic [1:0] credits;

  logic       v1, rdy1, ci1, f1, txv1, idle1, ov1;
  logic [7:0] d1, txd1;
  logic       cr1;

  int passed = 0;
  int total  = 0;

  credit_sender #(.data_t(logic [7:0]), .DEPTH(2)) u_dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .credit_in(credit_in), .flush(flush),
    .credits(credits), .idle(idle), .overflow(overflow)
  );

  credit_sender #(.data_t(logic [7:0]), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .enq_valid(v1), .enq_ready(rdy1), .enq_data(d1),
    .tx_valid(txv1), .tx_data(txd1),
    .credit_in(ci1), .flush(f1),
    .credits(cr1), .idle(idle1), .overflow(ov1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ci;
    logic       f;
    logic       rdy;
    logic       txv;
    logic [7:0] txd;
    logic [1:0] cr;
    logic       idl;
    logic       ov;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic v, logic [7:0] d, logic ci, logic f, logic rdy,
                              logic txv, logic [7:0] txd, logic [1:0] cr, logic idl, logic ov);
    vec_t r;
    r.v = v; r.d = d; r.ci = ci; r.f = f; r.rdy = rdy;
    r.txv = txv; r.txd = txd; r.cr = cr; r.idl = idl; r.ov = ov;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  initial begin
    //            v  d      ci f  rdy txv txd    cr idl ov
    vecs[0]  = mk(1, 8'hA1, 0, 0, 1,  1,  8'hA1, 2'd1, 0, 0);
    vecs[1]  = mk(1, 8'hB2, 0, 0, 1,  1,  8'hB2, 2'd0, 0, 0);
    vecs[2]  = mk(1, 8'hC3, 0, 0, 0,  0,  8'h00, 2'd0, 0, 0);
    vecs[3]  = mk(1, 8'hC3, 0, 0, 0,  0,  8'h00, 2'd0, 0, 0);
    vecs[4]  = mk(1, 8'hC3, 0, 0, 0,  0,  8'h00, 2'd0, 0, 0);
    vecs[5]  = mk(1, 8'hC3, 1, 0, 0,  0,  8'h00, 2'd1, 0, 0);
    vecs[6]  = mk(1, 8'hC3, 0, 0, 1,  1,  8'hC3, 2'd0, 0, 0);
    vecs[7]  = mk(0, 8'h00, 1, 0, 0,  0,  8'h00, 2'd1, 0, 0);
    vecs[8]  = mk(1, 8'hD4, 1, 0, 1,  1,  8'hD4, 2'd1, 0, 0);
    vecs[9]  = mk(1, 8'hE5, 0, 0, 1,  1,  8'hE5, 2'd0, 0, 0);
    vecs[10] = mk(0, 8'h00, 1, 0, 0,  0,  8'h00, 2'd1, 0, 0);
    vecs[11] = mk(0, 8'h00, 1, 0, 1,  0,  8'h00, 2'd2, 1, 0);
    vecs[12] = mk(0, 8'h00, 1, 0, 1,  0,  8'h00, 2'd2, 1, 1);
    vecs[13] = mk(0, 8'h00, 0, 1, 0,  0,  8'h00, 2'd2, 1, 1);
    vecs[14] = mk(1, 8'hF6, 0, 0, 1,  1,  8'hF6, 2'd1, 0, 1);
    vecs[15] = mk(1, 8'h07, 0, 0, 1,  1,  8'h07, 2'd0, 0, 1);
    vecs[16] = mk(1, 8'h08, 1, 1, 0,  0,  8'h00, 2'd2, 1, 1);
    vecs[17] = mk(0, 8'h00, 0, 0, 1,  0,  8'h00, 2'd2, 1, 1);

    rst = 1'b1;
    enq_valid = 0; enq_data = '0; credit_in = 0; flush = 0;
    v1 = 0; d1 = '0; ci1 = 0; f1 = 0;
    #12 rst = 1'b0;
    #1;
    check("reset_credits", 32'(credits), 32'd2);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_idle", 32'(idle), 32'd1);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_ready", 32'(enq_ready), 32'd1);

    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      enq_valid = vecs[i].v; enq_data = vecs[i].d;
      credit_in = vecs[i].ci; flush = vecs[i].f;
      #1;
      check($sformatf("v%0d_ready", i), 32'(enq_ready), 32'(vecs[i].rdy));
      @(posedge clk); #1;
      check($sformatf("v%0d_tx_valid", i), 32'(tx_valid), 32'(vecs[i].txv));
      if (vecs[i].txv) check($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].txd));
      check($sformatf("v%0d_credits", i), 32'(credits), 32'(vecs[i].cr));
      check($sformatf("v%0d_idle", i), 32'(idle), 32'(vecs[i].idl));
      check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
    end

    // Async reset while an item is on the link, between clock edges.
    enq_valid = 1; enq_data = 8'h99; credit_in = 0; flush = 0;
    @(posedge clk); #1;
    check("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
    check("pre_rst_credits", 32'(credits), 32'd1);
    enq_valid = 0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("async_rst_credits", 32'(credits), 32'd2);
    check("async_rst_idle", 32'(idle), 32'd1);
    check("async_rst_overflow", 32'(overflow), 32'd0);
    check("async_rst_tx_data", 32'(tx_data), 32'd0);
    #1 rst = 1'b0;

    // DEPTH=1 instance: single credit, one-bit counter.
    @(posedge clk); #1;
    check("d1_reset_credits", 32'(cr1), 32'd1);
    v1 = 1; d1 = 8'h11;
    #1 check("d1_a_ready", 32'(rdy1), 32'd1);
    @(posedge clk); #1;
    check("d1_a_tx_valid", 32'(txv1), 32'd1);
    check("d1_a_tx_data", 32'(txd1), 32'h11);
    check("d1_a_credits", 32'(cr1), 32'd0);
    check("d1_a_idle", 32'(idle1), 32'd0);
    ci1 = 1; d1 = 8'h22;
    #1 check("d1_b_ready", 32'(rdy1), 32'd0);
    @(posedge clk); #1;
    check("d1_b_tx_valid", 32'(txv1), 32'd0);
    check("d1_b_credits", 32'(cr1), 32'd1);
    check("d1_b_idle", 32'(idle1), 32'd1);
    v1 = 0;
    #1 check("d1_c_ready", 32'(rdy1), 32'd1);
    @(posedge clk); #1;
    check("d1_c_credits", 32'(cr1), 32'd1);
    check("d1_c_overflow", 32'(ov1), 32'd1);
    ci1 = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
